// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the prefetch fetcher
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int INSTR_BYTES = 4;
    localparam int ENTRY_W     = $bits(fetch_entry_t);

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : prefetch queue with flush; storage is not reset
// Revision   : 1.0
// ============================================================================
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // At full, wr_ptr == rd_ptr: a same-cycle pop reads the old word before it is overwritten.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/prefetch_fetcher.sv
`default_nettype none
// ============================================================================
// prefetch_fetcher : memory-side fetch FSM feeding a decoder through a queue
// Revision         : 1.0
// ============================================================================
module prefetch_fetcher
    import fetch_pkg::*;
#(
    parameter  int          DEPTH    = 4,
    parameter  logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             decoder_ready,
    output logic             fetcher_valid,
    output logic [31:0]      instr,
    output logic [31:0]      fetcher_pc,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             mem_ready,
    input  logic             mem_valid,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      mem_addr,
    output logic             mem_instr,
    output logic [3:0]       mem_wstrb,
    output logic [CNT_W-1:0] occupancy
);

    localparam int OCC_W = CNT_W + 1;

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [OCC_W-1:0] occ_after_push;
    logic         room_after_push;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign mem_addr   = word_align(fetch_pc);
    assign mem_wstrb  = 4'b0000;
    assign mem_instr  = mem_ready;

    // Redirect cancels both queue operations in its cycle.
    assign push = (state == REQ) && mem_valid && !redirect_valid;
    assign pop  = fetcher_valid && decoder_ready && !redirect_valid;

    assign occ_after_push  = {1'b0, occupancy} + OCC_W'(1) - OCC_W'(pop);
    assign room_after_push = (occ_after_push < OCC_W'(DEPTH));

    assign push_entry    = '{pc: mem_addr, instr: mem_rdata};
    assign fetcher_valid = !empty;
    assign instr         = head_entry.instr;
    assign fetcher_pc    = head_entry.pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            fetch_pc  <= RESET_PC;
        end else begin
            if (redirect_valid)  fetch_pc <= word_align(redirect_pc);
            else if (push)       fetch_pc <= fetch_pc + 32'(INSTR_BYTES);

            case (state)
                IDLE: begin
                    if (!redirect_valid && !full) begin
                        state     <= REQ;
                        mem_ready <= 1'b1;
                    end
                end
                REQ: begin
                    // A response landing with the redirect is simply consumed; otherwise wait it out.
                    if (redirect_valid) begin
                        mem_ready <= 1'b0;
                        state     <= mem_valid ? IDLE : DISCARD;
                    end else if (mem_valid && !room_after_push) begin
                        mem_ready <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DISCARD: begin
                    if (mem_valid) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (full),
        .empty     (empty),
        .count     (occupancy),
        .head      (head_entry)
    );

endmodule
`default_nettype wire

// File: tb/tb_prefetch_fetcher.sv
`default_nettype none
// ============================================================================
// tb_prefetch_fetcher : scoreboard bench with a behavioural memory and fetch-stream model
// Revision            : 1.0
// ============================================================================
module tb_prefetch_fetcher;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             decoder_ready = 1'b0;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_pc = '0;
    logic             mem_valid = 1'b0;
    logic [31:0]      mem_rdata = '0;
    logic             fetcher_valid;
    logic [31:0]      instr;
    logic [31:0]      fetcher_pc;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic             mem_instr;
    logic [3:0]       mem_wstrb;
    logic [CNT_W-1:0] occupancy;

    always #5 clk = ~clk;

    prefetch_fetcher #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .decoder_ready  (decoder_ready),
        .fetcher_valid  (fetcher_valid),
        .instr          (instr),
        .fetcher_pc     (fetcher_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_ready      (mem_ready),
        .mem_valid      (mem_valid),
        .mem_rdata      (mem_rdata),
        .mem_addr       (mem_addr),
        .mem_instr      (mem_instr),
        .mem_wstrb      (mem_wstrb),
        .occupancy      (occupancy)
    );

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cycle = 0;
    int          pop_cyc[$];
    logic [31:0] pop_pc[$];

    // Memory model and expected fetch address
    logic [31:0] model_pc = RESET_PC;
    bit          outstanding = 0;
    bit          stale = 0;
    int          lat = 0;
    logic [31:0] cap_addr = '0;
    int          n_caps = 0;
    bit          prev_redirect = 0, prev_accept = 0, prev_mem_valid = 0;
    logic [31:0] prev_redir_pc = '0, prev_data = '0, prev_pc = '0;
    int          lat_mode = -1;
    int          ready_mode = 2;
    int          redir_rate = 0;
    bit          force_redir = 0;
    logic [31:0] force_pc = '0;

    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: compares the decoder-side view against the expected queue
    always @(negedge clk) begin
        if (reset_n) begin
            chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
            chk("fetcher_valid", 32'(fetcher_valid), 32'(exp_q.size() != 0));
            chk("mem_wstrb", 32'(mem_wstrb), 32'h0);
            chk("mem_instr", 32'(mem_instr), 32'(mem_ready));
            if (exp_q.size() > 0) begin
                chk("head_pc", fetcher_pc, exp_q[0].pc);
                chk("head_instr", instr, exp_q[0].instr);
                if (decoder_ready && !redirect_valid) begin
                    pop_cyc.push_back(cycle);
                    pop_pc.push_back(fetcher_pc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        bit accept;
        @(posedge clk);
        #1;
        if (prev_mem_valid) outstanding = 0;
        if (prev_redirect) begin
            exp_q.delete();
            model_pc = prev_redir_pc & ~32'h3;
        end else if (prev_accept) begin
            exp_q.push_back('{pc: prev_pc, instr: prev_data});
            model_pc = model_pc + 32'd4;
        end
        if (mem_ready && !outstanding) begin
            chk("mem_addr", mem_addr, model_pc);
            outstanding = 1;
            stale = 0;
            cap_addr = model_pc;
            n_caps++;
            lat = (lat_mode < 0) ? int'($urandom_range(2, 0)) : lat_mode;
        end else if (outstanding && !stale) begin
            chk("mem_ready_hold", 32'(mem_ready), 32'h1);
            chk("mem_addr_hold", mem_addr, cap_addr);
        end
        redirect_valid = 1'b0;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc = force_pc;
            force_redir = 0;
        end else if (redir_rate > 0 && $urandom_range(redir_rate - 1, 0) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        end
        if (redirect_valid && outstanding) stale = 1;
        mem_valid = 1'b0;
        if (outstanding) begin
            if (lat == 0) begin
                mem_valid = 1'b1;
                mem_rdata = $urandom;
            end else begin
                lat--;
            end
        end
        accept = mem_valid && !stale && !redirect_valid;
        decoder_ready = (ready_mode == 2) ? 1'($urandom_range(1, 0)) : (ready_mode == 1);
        prev_mem_valid = mem_valid;
        prev_redirect  = redirect_valid;
        prev_redir_pc  = redirect_pc;
        prev_accept    = accept;
        prev_data      = mem_rdata;
        prev_pc        = cap_addr;
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("rst_fetcher_valid", 32'(fetcher_valid), 32'h0);
        chk("rst_mem_ready", 32'(mem_ready), 32'h0);
        chk("rst_mem_instr", 32'(mem_instr), 32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_fetcher_pc", fetcher_pc, 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        exp_q.delete();
        outstanding = 0;
        stale = 0;
        model_pc = RESET_PC;
        prev_redirect = 0;
        prev_accept = 0;
        prev_mem_valid = 0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        int c0;
        // Zero-wait memory, decoder always ready: PCs 0,4,8,12 pop in consecutive cycles
        do_reset();
        lat_mode = 0; ready_mode = 1; redir_rate = 0;
        pop_pc.delete(); pop_cyc.delete();
        repeat (12) step();
        if (pop_pc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("stream_pc", pop_pc[i], RESET_PC + 32'(4 * i));
                chk("stream_consecutive", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
            end
        end else begin
            timeout("stream_pops");
        end

        // Decoder stalled: queue fills, requests stop, head stays at the first fetch
        do_reset();
        lat_mode = -1; ready_mode = 0;
        repeat (20) step();
        chk("fill_occupancy", 32'(occupancy), 32'(DEPTH));
        chk("fill_mem_ready", 32'(mem_ready), 32'h0);
        chk("fill_head_pc", fetcher_pc, RESET_PC);
        if (exp_q.size() > 0) chk("fill_head_instr", instr, exp_q[0].instr);
        else timeout("fill_model_empty");

        // Redirect while a response is pending
        ready_mode = 1; lat_mode = 3;
        for (int k = 0; k < 20 && !(outstanding && lat >= 1); k++) step();
        if (!(outstanding && lat >= 1)) timeout("pending_request");
        force_redir = 1; force_pc = 32'h0000_0100;
        step();
        step();
        chk("redirect_flush_occ", 32'(occupancy), 32'h0);
        lat_mode = 0;
        c0 = n_caps;
        for (int k = 0; k < 20 && n_caps == c0; k++) step();
        if (n_caps > c0) chk("redirect_addr", cap_addr, 32'h0000_0100);
        else timeout("redirect_request");

        // Address wrap at the top of the address space
        force_redir = 1; force_pc = 32'hFFFF_FFFC;
        step();
        c0 = n_caps;
        for (int k = 0; k < 20 && n_caps < c0 + 1; k++) step();
        if (n_caps >= c0 + 1) chk("wrap_first", cap_addr, 32'hFFFF_FFFC);
        else timeout("wrap_first_request");
        for (int k = 0; k < 20 && n_caps < c0 + 2; k++) step();
        if (n_caps >= c0 + 2) chk("wrap_second", cap_addr, 32'h0);
        else timeout("wrap_second_request");

        // Randomized traffic
        lat_mode = -1; ready_mode = 2; redir_rate = 12;
        repeat (1500) step();

        // Reset pulsed while a request is in flight
        redir_rate = 0; lat_mode = 3;
        for (int k = 0; k < 40 && !(outstanding && mem_ready); k++) step();
        if (!(outstanding && mem_ready)) timeout("midreq_request");
        do_reset();
        lat_mode = -1;
        c0 = n_caps;
        step();
        chk("post_reset_req_count", 32'(n_caps - c0), 32'h1);
        chk("post_reset_addr", cap_addr, RESET_PC);

        redir_rate = 12;
        repeat (1500) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
